// File: rtl/mult_share_pkg.sv
// Shared types and default constants for the multiplier-sharing arbiter.
// Imported by the arbiter top level.
package mult_share_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      RESP = 2'd2
   } mult_share_state_t;

   localparam int MS_WIDTH   = 8;
   localparam int MS_NUM_REQ = 4;

endpackage

// File: rtl/param_multiplier.sv
// Unsigned combinational multiplier producing the full double-width product.
module param_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] product
);

   // Zero-extend both operands so the product is never truncated
   assign product = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from N-1 back to 0.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any
);

   logic [IW:0]   sum_s;
   logic [IW-1:0] idx_s;

   // Scan requesters in priority order starting from ptr
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      sum_s     = '0;
      idx_s     = '0;
      for (int i = 0; i < N; i++) begin
         sum_s = {1'b0, ptr} + (IW+1)'(i);
         if (sum_s >= (IW+1)'(N)) begin
            sum_s = sum_s - (IW+1)'(N);
         end else begin
            sum_s = sum_s;
         end
         idx_s = sum_s[IW-1:0];
         if (!any && req[idx_s]) begin
            any          = 1'b1;
            grant[idx_s] = 1'b1;
            grant_idx    = idx_s;
         end else begin
            any = any;
         end
      end
   end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one param_multiplier among NUM_REQ requesters with round-robin
// grants and a single backpressured response channel.
module mult_share_arbiter
   import mult_share_pkg::*;
#(
   parameter int WIDTH   = MS_WIDTH,
   parameter int NUM_REQ = MS_NUM_REQ,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [2*WIDTH-1:0]       rsp_product,
   output logic [IDW-1:0]           rsp_id
);

   mult_share_state_t state_r, state_nxt_s;

   logic [IDW-1:0]     ptr_r;
   logic [WIDTH-1:0]   op_a_r;
   logic [WIDTH-1:0]   op_b_r;
   logic [IDW-1:0]     op_id_r;
   logic [NUM_REQ-1:0] grant_s;
   logic [IDW-1:0]     grant_idx_s;
   logic               any_s;
   logic               take_s;
   logic [IDW-1:0]     ptr_nxt_s;
   logic [2*WIDTH-1:0] mul_p_s;
   logic [WIDTH-1:0]   a_arr_s [NUM_REQ];
   logic [WIDTH-1:0]   b_arr_s [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr_s[gi] = req_a[gi*WIDTH +: WIDTH];
      assign b_arr_s[gi] = req_b[gi*WIDTH +: WIDTH];
   end

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (IDW)
   ) u_rr (
      .req       (req_valid),
      .ptr       (ptr_r),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .any       (any_s)
   );

   param_multiplier #(
      .WIDTH (WIDTH)
   ) u_mul (
      .a       (op_a_r),
      .b       (op_b_r),
      .product (mul_p_s)
   );

   assign ptr_nxt_s = (grant_idx_s == IDW'(NUM_REQ-1)) ? '0 : grant_idx_s + IDW'(1);

   // Next-state and grant decode; ready is suppressed while rst is high
   always_comb begin
      state_nxt_s = state_r;
      req_ready   = '0;
      take_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (any_s && !rst) begin
               req_ready   = grant_s;
               take_s      = 1'b1;
               state_nxt_s = MUL;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         MUL: begin
            state_nxt_s = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, pointer, operand and response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         ptr_r       <= '0;
         op_a_r      <= '0;
         op_b_r      <= '0;
         op_id_r     <= '0;
         rsp_valid   <= 1'b0;
         rsp_product <= '0;
         rsp_id      <= '0;
      end else begin
         state_r   <= state_nxt_s;
         rsp_valid <= (state_nxt_s == RESP);
         if (take_s) begin
            op_a_r  <= a_arr_s[grant_idx_s];
            op_b_r  <= b_arr_s[grant_idx_s];
            op_id_r <= grant_idx_s;
            ptr_r   <= ptr_nxt_s;
         end
         if (state_r == MUL) begin
            rsp_product <= mul_p_s;
            rsp_id      <= op_id_r;
         end
      end
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter: directed stimulus pushes expected
// {id, product} pairs, a negedge monitor pops them on each response handshake.
module tb_mult_share_arbiter;

   localparam int W = 8;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [2*W-1:0] rsp_product;
   logic [1:0]     rsp_id;

   int n_vec = 0;
   int n_err = 0;
   logic [17:0] exp_q [$];

   always #5 clk = ~clk;

   mult_share_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_product (rsp_product),
      .rsp_id      (rsp_id)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   // Response monitor: a valid&&ready seen at negedge is consumed at the next edge
   always @(negedge clk) begin
      logic [17:0] e;
      if (!rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_unexpected: got id %0d product %0h, expected none", rsp_id, rsp_product);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(e[17:16]));
            chk("rsp_product", 32'(rsp_product), 32'(e[15:0]));
         end
      end
   end

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      step(); step(); step();
      chk("reset_req_ready", 32'(req_ready), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_product", 32'(rsp_product), 32'd0);
      chk("reset_rsp_id", 32'(rsp_id), 32'd0);
      rst = 1'b0;

      // Single request from requester 2: 13*11 = 143
      set_op(2, 8'd13, 8'd11);
      req_valid = 4'b0100;
      #1;
      chk("single_ready", 32'(req_ready), 32'b0100);
      exp_q.push_back({2'd2, 16'd143});
      step();
      req_valid = 4'b0000;
      chk("single_mul_no_valid", 32'(rsp_valid), 32'd0);
      chk("single_mul_ready", 32'(req_ready), 32'd0);
      step();
      chk("single_latency", 32'(rsp_valid), 32'd1);
      step();

      // Max operands from requester 0: 255*255 = 0xFE01
      set_op(0, 8'd255, 8'd255);
      req_valid = 4'b0001;
      #1;
      chk("max_ready", 32'(req_ready), 32'b0001);
      exp_q.push_back({2'd0, 16'hFE01});
      step();
      req_valid = 4'b0000;
      step();
      chk("max_latency", 32'(rsp_valid), 32'd1);
      step();

      // Pointer back to 0, then all four requesters continuously valid
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_op(0, 8'd10, 8'd7);
      set_op(1, 8'd20, 8'd9);
      set_op(2, 8'd30, 8'd11);
      set_op(3, 8'd40, 8'd13);
      req_valid = 4'b1111;
      exp_q.push_back({2'd0, 16'd70});
      exp_q.push_back({2'd1, 16'd180});
      exp_q.push_back({2'd2, 16'd330});
      exp_q.push_back({2'd3, 16'd520});
      exp_q.push_back({2'd0, 16'd70});
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("rr_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
         step();
         chk("rr_mul_ready", 32'(req_ready), 32'd0);
         step();
         chk("rr_resp_valid", 32'(rsp_valid), 32'd1);
         chk("rr_resp_ready", 32'(req_ready), 32'd0);
         step();
      end
      req_valid = 4'b0000;

      // Backpressure: requesters 1 and 3 compete, response stalled 10 cycles
      set_op(1, 8'd100, 8'd200);
      rsp_ready = 1'b0;
      req_valid = 4'b1010;
      #1;
      chk("bp_grant", 32'(req_ready), 32'b0010);
      exp_q.push_back({2'd1, 16'd20000});
      exp_q.push_back({2'd3, 16'd520});
      step();
      req_valid = 4'b1000;
      step();
      for (int k = 0; k < 10; k++) begin
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_product", 32'(rsp_product), 32'd20000);
         chk("bp_id", 32'(rsp_id), 32'd1);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         step();
      end
      rsp_ready = 1'b1;
      step();
      chk("bp_after_release_valid", 32'(rsp_valid), 32'd0);
      chk("bp_next_grant", 32'(req_ready), 32'b1000);
      step();
      req_valid = 4'b0000;
      step();
      chk("bp_next_latency", 32'(rsp_valid), 32'd1);
      step();

      // Reset while in MUL discards the request
      set_op(2, 8'd5, 8'd6);
      req_valid = 4'b0100;
      #1;
      chk("rst_mul_grant", 32'(req_ready), 32'b0100);
      step();
      req_valid = 4'b0000;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         chk("rst_mul_no_rsp", 32'(rsp_valid), 32'd0);
         step();
      end
      req_valid = 4'b1111;
      #1;
      chk("rst_mul_ptr_zero", 32'(req_ready), 32'b0001);
      exp_q.push_back({2'd0, 16'd70});
      step();
      req_valid = 4'b0000;
      step();
      step();

      // Idle for 20 cycles, then confirm the FSM still grants immediately
      for (int k = 0; k < 20; k++) begin
         chk("idle_req_ready", 32'(req_ready), 32'd0);
         chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
         step();
      end
      req_valid = 4'b1000;
      #1;
      chk("idle_then_grant", 32'(req_ready), 32'b1000);
      exp_q.push_back({2'd3, 16'd520});
      step();
      req_valid = 4'b0000;

      for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
         step();
      end
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
